// File: rtl/hawk_video_extract_temp.sv
`default_nettype none
// ============================================================================
// Module   : hawk_video_extract_temp
// Purpose  : Receive-side temperature extraction on an Avalon-ST video path.
//            Inside each video packet (SOP data[3:0] == 0) the first beat
//            after SOP is the temperature word. That beat is removed from the
//            stream and held in temp_data. The remaining pixels are forwarded
//            with one cycle of latency. Pixels per frame are counted against
//            SIZE_X*SIZE_Y, and short or long frames are flagged. Control
//            packets and stray beats pass through unchanged.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   stream_clk        in   1  stream clock, rising edge
//   reset_n           in   1  asynchronous active-low reset
//   enable            in   1  1 = extract, 0 = transparent pass-through
//   stream_in_sop     in   1  start of packet
//   stream_in_valid   in   1  beat valid
//   stream_in_data    in  16  beat data
//   stream_in_eop     in   1  end of packet
//   stream_out_sop    out  1  registered SOP
//   stream_out_valid  out  1  registered valid
//   stream_out_data   out 16  registered data
//   stream_out_eop    out  1  registered EOP
//   temp_data         out 16  last captured temperature word
//   temp_valid        out  1  pulse when temp_data updates
//   frame_err_short   out  1  pulse: frame ended or aborted too short
//   frame_err_long    out  1  pulse: frame ended too long
// ============================================================================
module hawk_video_extract_temp #(
  parameter int SIZE_X = 640,
  parameter int SIZE_Y = 480
) (
  input  logic        stream_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        stream_in_sop,
  input  logic        stream_in_valid,
  input  logic [15:0] stream_in_data,
  input  logic        stream_in_eop,
  output logic        stream_out_sop,
  output logic        stream_out_valid,
  output logic [15:0] stream_out_data,
  output logic        stream_out_eop,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        frame_err_short,
  output logic        frame_err_long
);

  localparam logic [19:0] EXP_COUNT = 20'(SIZE_X * SIZE_Y);
  localparam logic [19:0] CNT_MAX   = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PIX  = 2'd2,
    CTRL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        out_sop_q, out_sop_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_eop_q, out_eop_d;
  logic [15:0] temp_data_q, temp_data_d;
  logic        temp_valid_q, temp_valid_d;
  logic        err_short_q, err_short_d;
  logic        err_long_q, err_long_d;

  // Pixel count including the current beat, saturating so a runaway
  // stream can never wrap back into the "correct size" window.
  logic [19:0] cnt_inc;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge stream_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 20'd0;
      out_sop_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 16'h0000;
      out_eop_q    <= 1'b0;
      temp_data_q  <= 16'h0000;
      temp_valid_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_sop_q    <= out_sop_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_eop_q    <= out_eop_d;
      temp_data_q  <= temp_data_d;
      temp_valid_q <= temp_valid_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_sop_d    = 1'b0;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_eop_d    = 1'b0;
    temp_data_d  = temp_data_q;
    temp_valid_d = 1'b0;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;

    if (stream_in_valid) begin
      if (stream_in_sop) begin
        // A new SOP while a video frame is still open aborts that frame.
        if ((state_q == HDR) || (state_q == PIX)) begin
          err_short_d = 1'b1;
        end
        out_valid_d = 1'b1;
        out_sop_d   = 1'b1;
        out_eop_d   = stream_in_eop;
        out_data_d  = stream_in_data;
        cnt_d       = 20'd0;
        // Mode is sampled only here, so an enable change mid-frame lets
        // the current frame finish in its original mode. With enable low
        // the FSM stays in IDLE, where every beat is forwarded verbatim.
        if (enable && !stream_in_eop) begin
          state_d = (stream_in_data[3:0] == 4'h0) ? HDR : CTRL;
        end else begin
          state_d = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            // Stray beat outside any packet: pass it along untouched.
            out_valid_d = 1'b1;
            out_eop_d   = stream_in_eop;
            out_data_d  = stream_in_data;
          end
          HDR: begin
            // Temperature word is consumed, not forwarded.
            temp_data_d  = stream_in_data;
            temp_valid_d = 1'b1;
            if (stream_in_eop) begin
              // Packet carried no pixels: close it with a dummy EOP beat
              // so the sink still sees a well-formed packet.
              out_valid_d = 1'b1;
              out_eop_d   = 1'b1;
              out_data_d  = 16'h0000;
              err_short_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = PIX;
            end
          end
          PIX: begin
            out_valid_d = 1'b1;
            out_eop_d   = stream_in_eop;
            out_data_d  = stream_in_data;
            cnt_d       = cnt_inc;
            if (stream_in_eop) begin
              err_short_d = (cnt_inc < EXP_COUNT);
              err_long_d  = (cnt_inc > EXP_COUNT);
              state_d     = IDLE;
            end
          end
          CTRL: begin
            out_valid_d = 1'b1;
            out_eop_d   = stream_in_eop;
            out_data_d  = stream_in_data;
            if (stream_in_eop) begin
              state_d = IDLE;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign stream_out_sop   = out_sop_q;
  assign stream_out_valid = out_valid_q;
  assign stream_out_data  = out_data_q;
  assign stream_out_eop   = out_eop_q;
  assign temp_data        = temp_data_q;
  assign temp_valid       = temp_valid_q;
  assign frame_err_short  = err_short_q;
  assign frame_err_long   = err_long_q;

endmodule
`default_nettype wire

// File: doc/hawk_video_extract_temp.md
Name: hawk_video_extract_temp

Overview:
- Receive-side counterpart of the temperature-insertion stage on the Avalon-ST video path.
- Sits after the link and before the video sink. Within each video packet, it removes the first data beat after SOP (the temperature word) and latches it into a register.
- Passes the remaining pixels downstream with a fixed 1-cycle latency.
- Counts the pixels in each frame against the expected size and flags short and long frames. Non-video (control) packets pass through untouched.

Parameters:
- SIZE_X, 640, active pixels per line.
- SIZE_Y, 480, active lines per frame. Expected pixel count is SIZE_X*SIZE_Y; the counter width is fixed at 20 bits.

Ports:
- stream_clk  in  1  stream clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = extract; 0 = transparent pass-through with 1-cycle latency.
- stream_in_sop  in  1  start of packet.
- stream_in_valid  in  1  beat valid.
- stream_in_data  in  16  beat data.
- stream_in_eop  in  1  end of packet.
- stream_out_sop  out  1  registered SOP.
- stream_out_valid  out  1  registered valid.
- stream_out_data  out  16  registered data.
- stream_out_eop  out  1  registered EOP.
- temp_data  out  16  last captured temperature word; holds between frames.
- temp_valid  out  1  one-cycle pulse when temp_data updates.
- frame_err_short  out  1  one-cycle pulse: frame ended or was aborted with fewer pixels than expected.
- frame_err_long  out  1  one-cycle pulse: frame ended with more pixels than expected.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, pixel counter 0.
- No backpressure. Every input beat is qualified by stream_in_valid only; beats with valid=0 are ignored and the state is held.
- Outputs are registered. An input beat on cycle N appears on cycle N+1, except a dropped beat, which gives out_valid=0 on N+1.
- enable=0: every valid beat is forwarded unchanged (1 cycle later), the FSM is forced to IDLE, and no temp capture or error pulses occur. A change of enable takes effect at the next SOP; a frame already in progress completes in its current mode.
- FSM states:
  - IDLE: wait for a valid beat with sop=1.
  - HDR: next valid beat is the temperature word.
  - PIX: pixels.
  - CTRL: non-video packet.
- IDLE + valid sop beat: the beat is forwarded with sop=1.
  - data[3:0]==4'h0 → HDR, counter cleared.
  - Otherwise → CTRL.
  - An sop beat that also has eop=1 is forwarded and the FSM stays in IDLE.
- HDR + valid non-sop beat:
  - Beat not forwarded; temp_data <= data; temp_valid=1 next cycle.
  - eop=0 → PIX.
  - eop=1 → emit one beat (data 16'h0000, sop=0, eop=1) to close the packet, pulse frame_err_short, → IDLE.
- PIX + valid non-sop beat: forward the beat and increment the counter, saturating at 2^20-1. On eop=1, compare the count including this beat:
  - Less than SIZE_X*SIZE_Y → frame_err_short.
  - Greater → frame_err_long.
  - Then → IDLE.
- CTRL: forward every beat unchanged; eop → IDLE. No counting or capture.
- Valid sop beat in HDR or PIX (aborted frame):
  - Pulse frame_err_short for the aborted frame.
  - Treat the beat as a new SOP exactly as in IDLE. The sop beat is forwarded; no eop is synthesised for the aborted frame.
- Valid sop beat in CTRL: restart the SOP decode as in IDLE; no error pulse.
- Valid non-sop beat in IDLE: forward unchanged (stray data, no error).
- The error pulses and temp_valid are registered, aligned to the output cycle of the beat that caused them. In a given cycle, only one of frame_err_short and frame_err_long is ever asserted.
- Reset mid-frame: outputs clear immediately and temp_data returns to 0. The first packet after release is decoded from IDLE.

Test Plan (bench overrides SIZE_X=4, SIZE_Y=2 → 8 pixels):
1. enable=1; send SOP(0x0000), 0x1A2B, pixels 1..8 with eop on 8 → output is SOP, 1..8 with eop, out_valid low for 1 cycle; temp_data=0x1A2B; temp_valid single pulse; no error pulses.
2. Same frame with 6 pixels (eop on 6th) → frame_err_short pulses with the eop beat; with 9 pixels → frame_err_long pulses with the 9th beat.
3. SOP(0x000F), then 3 beats 0xAAAA/0xBBBB/0xCCCC(eop) → all 4 beats forwarded verbatim; temp_data unchanged; no pulses.
4. Valid gaps: insert 2 idle cycles between every beat of scenario 1 → identical beat sequence and capture; state held across gaps.
5. Abort and short header:
   - SOP, 0x0055, 3 pixels, then a new SOP → frame_err_short pulses with the new SOP beat; the new frame decodes normally.
   - SOP, header 0x0077 with eop → a 0x0000 eop beat is emitted; temp_data=0x0077; frame_err_short pulses.
6. enable=0: scenario 1 stream → all 10 beats forwarded 1 cycle late, no drop, temp_valid never pulses. Assert reset_n low mid-frame → all outputs 0 asynchronously; temp_data=0.
